// File: rtl/alarm_ctrl.sv
// Alarm unit fed by the time-of-day counter: programmable alarm time,
// edge-detected match, and an OFF/RING/SNOOZE state machine driving a buzzer.
module alarm_ctrl #(
  parameter int SNOOZE_SEC   = 300,
  parameter int RING_SEC     = 60,
  parameter int ALARM_HR_RST = 6,
  parameter int ALARM_MN_RST = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] hr,
  input  logic [5:0] mn,
  input  logic [5:0] sc,
  input  logic       sec_tick,
  input  logic       alarm_en,
  input  logic       alarm_set,
  input  logic       up,
  input  logic       down,
  input  logic       snooze,
  input  logic       stop,
  output logic [4:0] alarm_hr,
  output logic [5:0] alarm_mn,
  output logic [1:0] edit_field,
  output logic       ringing,
  output logic       snoozing,
  output logic       buzzer
);

  localparam logic [1:0] ED_NONE = 2'b00;
  localparam logic [1:0] ED_HOUR = 2'b01;
  localparam logic [1:0] ED_MIN  = 2'b10;

  localparam logic [1:0] ST_OFF    = 2'b00;
  localparam logic [1:0] ST_RING   = 2'b01;
  localparam logic [1:0] ST_SNOOZE = 2'b10;

  localparam logic [9:0] RING_LAST = 10'(RING_SEC - 1);
  localparam logic [9:0] SNZ_LAST  = 10'(SNOOZE_SEC - 1);

  logic [1:0] ring_st;
  logic [9:0] ring_cnt, snz_cnt;
  logic       buzz_q;
  logic       match, match_q, trigger;
  logic       inc, dec;

  assign inc     = up & ~down;
  assign dec     = down & ~up;
  assign match   = (hr == alarm_hr) && (mn == alarm_mn) && (sc == 6'd0);
  assign trigger = match && !match_q && alarm_en && (edit_field == ED_NONE) && (ring_st == ST_OFF);

  // Edit FSM and alarm time registers; alarm_set is swallowed by the ring FSM
  // whenever it is active.
  always_ff @(posedge clk) begin
    if (rst) begin
      alarm_hr   <= 5'(ALARM_HR_RST);
      alarm_mn   <= 6'(ALARM_MN_RST);
      edit_field <= ED_NONE;
    end else begin
      if (alarm_set && ring_st == ST_OFF) begin
        case (edit_field)
          ED_NONE: edit_field <= ED_HOUR;
          ED_HOUR: edit_field <= ED_MIN;
          default: edit_field <= ED_NONE;
        endcase
      end
      if (edit_field == ED_HOUR) begin
        if (inc)      alarm_hr <= (alarm_hr == 5'd23) ? 5'd0 : alarm_hr + 5'd1;
        else if (dec) alarm_hr <= (alarm_hr == 5'd0) ? 5'd23 : alarm_hr - 5'd1;
      end
      if (edit_field == ED_MIN) begin
        if (inc)      alarm_mn <= (alarm_mn == 6'd59) ? 6'd0 : alarm_mn + 6'd1;
        else if (dec) alarm_mn <= (alarm_mn == 6'd0) ? 6'd59 : alarm_mn - 6'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) match_q <= 1'b0;
    else     match_q <= match;
  end

  // Ring FSM: disarm beats everything, then stop/alarm_set, then snooze, then timers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ring_st  <= ST_OFF;
      ring_cnt <= '0;
      snz_cnt  <= '0;
      buzz_q   <= 1'b0;
    end else if (!alarm_en) begin
      ring_st <= ST_OFF;
      buzz_q  <= 1'b0;
    end else begin
      case (ring_st)
        ST_OFF: begin
          if (trigger) begin
            ring_st  <= ST_RING;
            ring_cnt <= '0;
            buzz_q   <= 1'b0;
          end
        end
        ST_RING: begin
          if (stop || alarm_set) begin
            ring_st <= ST_OFF;
            buzz_q  <= 1'b0;
          end else if (snooze) begin
            ring_st <= ST_SNOOZE;
            snz_cnt <= '0;
            buzz_q  <= 1'b0;
          end else if (sec_tick) begin
            if (ring_cnt == RING_LAST) begin
              ring_st <= ST_OFF;
              buzz_q  <= 1'b0;
            end else begin
              ring_cnt <= ring_cnt + 10'd1;
              buzz_q   <= ~buzz_q;
            end
          end
        end
        ST_SNOOZE: begin
          if (stop || alarm_set) begin
            ring_st <= ST_OFF;
          end else if (sec_tick) begin
            if (snz_cnt == SNZ_LAST) begin
              ring_st  <= ST_RING;
              ring_cnt <= '0;
              buzz_q   <= 1'b0;
            end else begin
              snz_cnt <= snz_cnt + 10'd1;
            end
          end
        end
        default: ring_st <= ST_OFF;
      endcase
    end
  end

  assign ringing  = (ring_st == ST_RING);
  assign snoozing = (ring_st == ST_SNOOZE);
  assign buzzer   = buzz_q & ringing;

endmodule
